// File: rtl/prng_arbiter_pkg.sv
// Shared types for the PRNG arbiter: seeding-sequence FSM states.
package veer_types;

    // Seeding sequence: load seed, discard warm-up output, then hand out random bits.
    typedef enum logic [1:0] {
        StReseed = 2'd0,
        StWarmup = 2'd1,
        StServe  = 2'd2
    } prng_state_e;

endpackage

// File: rtl/prng_arbiter_lfsr_prng.sv
// 64-bit XNOR Fibonacci LFSR (taps 64,63,61,60). Loads seed_i while rst_l is low.
// The all-zero state is legal; XNOR feedback shifts ones in from it.
module lfsr_prng #(
    parameter int unsigned SIZE = 3
) (
    input  logic            clk,
    input  logic            rst_l,
    input  logic [63:0]     seed_i,
    output logic [SIZE-1:0] output_number_o
);

    logic [63:0] lfsr_q;
    logic        fb;

    assign fb = ~(lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59]);

    // Free-running shift; seed load is asynchronous and level-held.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            lfsr_q <= seed_i;
        end else begin
            lfsr_q <= {lfsr_q[62:0], fb};
        end
    end

    assign output_number_o = lfsr_q[SIZE-1:0];

endmodule

// File: rtl/prng_arbiter.sv
// Shares one LFSR among NREQ consumers: seeding/warm-up sequencing, round-robin
// grants and a minimum grant stride so no two consumers see overlapping bits.
module prng_arbiter
    import veer_types::*;
#(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned SIZE       = 3,
    parameter int unsigned STRIDE     = SIZE,
    parameter int unsigned WARMUP     = 64,
    parameter logic [63:0] RESET_SEED = 64'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [SIZE-1:0] rnd_o,
    input  logic            reseed_req_i,
    input  logic [63:0]     seed_i,
    output logic            busy_o
);

    localparam int unsigned PtrW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned StrW  = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int unsigned WarmW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

    prng_state_e      state_q, state_d;
    logic [WarmW-1:0] warm_cnt_q, warm_cnt_d;
    logic [StrW-1:0]  stride_cnt_q, stride_cnt_d;
    logic [PtrW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [63:0]      seed_q, seed_d;
    logic             prng_clr_q, prng_clr_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [SIZE-1:0]  rnd_q, rnd_d;
    logic [SIZE-1:0]  prng_out;
    logic             prng_rst_l;
    logic             grant_ok;
    logic [PtrW-1:0]  win;

    // First set request at or above ptr, wrapping modulo NREQ.
    function automatic logic [PtrW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                                 input logic [PtrW-1:0] ptr);
        logic [PtrW-1:0] pick;
        logic            found;
        int unsigned     pos;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            pos = (32'(ptr) + i) % NREQ;
            if (!found && req[pos]) begin
                pick  = PtrW'(pos);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Clear comes from a flop, so the PRNG async reset never sees a combinational glitch.
    assign prng_rst_l = ~rst & ~prng_clr_q;

    lfsr_prng #(
        .SIZE(SIZE)
    ) u_lfsr_prng (
        .clk             (clk),
        .rst_l           (prng_rst_l),
        .seed_i          (seed_q),
        .output_number_o (prng_out)
    );

    assign grant_ok = (state_q == StServe) && (stride_cnt_q == '0) && (|req_i) && !reseed_req_i;
    assign win      = rr_pick(req_i, rr_ptr_q);

    // Grant, pointer and stride next-state.
    always_comb begin
        gnt_d        = '0;
        rnd_d        = rnd_q;
        rr_ptr_d     = rr_ptr_q;
        stride_cnt_d = stride_cnt_q;
        if (grant_ok) begin
            gnt_d        = NREQ'(1) << win;
            rnd_d        = prng_out;
            rr_ptr_d     = (win == PtrW'(NREQ - 1)) ? '0 : win + PtrW'(1);
            stride_cnt_d = StrW'(STRIDE - 1);
        end else if (stride_cnt_q != '0) begin
            stride_cnt_d = stride_cnt_q - StrW'(1);
        end
    end

    // Seeding FSM; a reseed request from any state restarts the sequence.
    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        seed_d     = seed_q;
        prng_clr_d = 1'b0;
        if (reseed_req_i) begin
            seed_d     = seed_i;
            state_d    = StReseed;
            prng_clr_d = 1'b1;
        end else begin
            unique case (state_q)
                StReseed: begin
                    state_d    = StWarmup;
                    warm_cnt_d = WarmW'(WARMUP);
                end
                StWarmup: begin
                    if (warm_cnt_q == '0) begin
                        state_d = StServe;
                    end else begin
                        warm_cnt_d = warm_cnt_q - WarmW'(1);
                    end
                end
                StServe: ;
                default: begin
                    state_d    = StWarmup;
                    warm_cnt_d = WarmW'(WARMUP);
                end
            endcase
        end
    end

    // State registers; reset starts in warm-up with the PRNG held on RESET_SEED.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StWarmup;
            warm_cnt_q   <= WarmW'(WARMUP);
            stride_cnt_q <= '0;
            rr_ptr_q     <= '0;
            seed_q       <= RESET_SEED;
            prng_clr_q   <= 1'b0;
            gnt_q        <= '0;
            rnd_q        <= '0;
        end else begin
            state_q      <= state_d;
            warm_cnt_q   <= warm_cnt_d;
            stride_cnt_q <= stride_cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            seed_q       <= seed_d;
            prng_clr_q   <= prng_clr_d;
            gnt_q        <= gnt_d;
            rnd_q        <= rnd_d;
        end
    end

    assign gnt_o  = gnt_q;
    assign rnd_o  = rnd_q;
    assign busy_o = (state_q != StServe);

endmodule

// File: tb/tb_prng_arbiter.sv
// Bench for prng_arbiter: a cycle table on a STRIDE=1 instance and a randomized run of a
// STRIDE=3 instance against a behavioural model (absolute cycle counts, per-edge LFSR).
module tb_prng_arbiter;

    localparam int NREQ     = 4;
    localparam int STRIDE_A = 3;
    localparam int WARMUP_A = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: STRIDE=3, WARMUP=3, seed 0.
    logic        rst_a = 1'b1;
    logic [3:0]  req_a = '0;
    logic [3:0]  gnt_a;
    logic [2:0]  rnd_a;
    logic        rs_a = 1'b0;
    logic [63:0] seed_a = '0;
    logic        busy_a;

    // Instance B: STRIDE=1, WARMUP=2.
    logic        rst_b = 1'b1;
    logic [3:0]  req_b = '0;
    logic [3:0]  gnt_b;
    logic [2:0]  rnd_b;
    logic        rs_b = 1'b0;
    logic [63:0] seed_b = '0;
    logic        busy_b;

    prng_arbiter #(
        .NREQ(4), .SIZE(3), .STRIDE(STRIDE_A), .WARMUP(WARMUP_A), .RESET_SEED(64'h0)
    ) u_dut_a (
        .clk(clk), .rst(rst_a), .req_i(req_a), .gnt_o(gnt_a), .rnd_o(rnd_a),
        .reseed_req_i(rs_a), .seed_i(seed_a), .busy_o(busy_a)
    );

    prng_arbiter #(
        .NREQ(4), .SIZE(3), .STRIDE(1), .WARMUP(2), .RESET_SEED(64'h0)
    ) u_dut_b (
        .clk(clk), .rst(rst_b), .req_i(req_b), .gnt_o(gnt_b), .rnd_o(rnd_b),
        .reseed_req_i(rs_b), .seed_i(seed_b), .busy_o(busy_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of instance A ----------------
    int          m_busy_left;   // edges still to go before grants are allowed
    int          m_cycle;       // edges since reset release
    int          m_next_ok;     // first edge index at which a grant may be decided
    int          m_last;        // last granted requester
    logic [63:0] m_lfsr;
    logic [63:0] m_seed;
    bit          m_load;        // this coming edge ends a seed-load cycle
    logic [3:0]  m_gnt;
    logic [2:0]  m_rnd;

    function automatic logic [63:0] lfsr_step(input logic [63:0] s);
        return {s[62:0], ~(s[63] ^ s[62] ^ s[60] ^ s[59])};
    endfunction

    task automatic model_reset();
        m_busy_left = WARMUP_A + 1;
        m_cycle     = 0;
        m_next_ok   = 0;
        m_last      = NREQ - 1;
        m_lfsr      = 64'h0;
        m_seed      = 64'h0;
        m_load      = 1'b0;
        m_gnt       = '0;
        m_rnd       = '0;
    endtask

    task automatic model_edge(input logic [3:0] req, input logic rs, input logic [63:0] seed);
        int k;
        m_gnt = '0;
        if (m_busy_left == 0 && m_cycle >= m_next_ok && req != 0 && !rs) begin
            for (int off = 1; off <= NREQ; off++) begin
                k = (m_last + off) % NREQ;
                if (req[k] && m_gnt == 0) begin
                    m_gnt[k]  = 1'b1;
                    m_last    = k;
                end
            end
            m_rnd     = m_lfsr[2:0];
            m_next_ok = m_cycle + STRIDE_A;
        end
        m_lfsr = m_load ? m_seed : lfsr_step(m_lfsr);
        if (rs) begin
            m_seed      = seed;
            m_busy_left = WARMUP_A + 2;
        end else if (m_busy_left > 0) begin
            m_busy_left--;
        end
        m_load = rs;
        m_cycle++;
    endtask

    task automatic step_a();
        model_edge(req_a, rs_a, seed_a);
        @(posedge clk);
        #1;
        check("a_gnt", 64'(gnt_a), 64'(m_gnt));
        check("a_rnd", 64'(rnd_a), 64'(m_rnd));
        check("a_busy", 64'(busy_a), 64'(m_busy_left != 0));
    endtask

    // ---------------- table for instance B ----------------
    typedef struct {
        logic [3:0] req;
        logic       rs;
        logic [3:0] gnt;
        logic       busy;
    } vec_t;

    vec_t tbl[19];

    initial begin
        int n;
        bit seen;

        // req 1111 held: warm-up, then grants 0,1,2,3,0 on consecutive cycles.
        tbl[0]  = '{4'b1111, 1'b0, 4'b0000, 1'b1};
        tbl[1]  = '{4'b1111, 1'b0, 4'b0000, 1'b1};
        tbl[2]  = '{4'b1111, 1'b0, 4'b0000, 1'b0};
        tbl[3]  = '{4'b1111, 1'b0, 4'b0001, 1'b0};
        tbl[4]  = '{4'b1111, 1'b0, 4'b0010, 1'b0};
        tbl[5]  = '{4'b1111, 1'b0, 4'b0100, 1'b0};
        tbl[6]  = '{4'b1111, 1'b0, 4'b1000, 1'b0};
        tbl[7]  = '{4'b1111, 1'b0, 4'b0001, 1'b0};
        // req 1010: pointer skips idle requesters.
        tbl[8]  = '{4'b1010, 1'b0, 4'b0010, 1'b0};
        tbl[9]  = '{4'b1010, 1'b0, 4'b1000, 1'b0};
        tbl[10] = '{4'b1010, 1'b0, 4'b0010, 1'b0};
        tbl[11] = '{4'b1010, 1'b0, 4'b1000, 1'b0};
        // Reseed while req 0100 pending: held through RESEED + 3 warm-up cycles.
        tbl[12] = '{4'b0100, 1'b1, 4'b0000, 1'b1};
        tbl[13] = '{4'b0100, 1'b0, 4'b0000, 1'b1};
        tbl[14] = '{4'b0100, 1'b0, 4'b0000, 1'b1};
        tbl[15] = '{4'b0100, 1'b0, 4'b0000, 1'b1};
        tbl[16] = '{4'b0100, 1'b0, 4'b0000, 1'b0};
        tbl[17] = '{4'b0100, 1'b0, 4'b0100, 1'b0};
        tbl[18] = '{4'b0000, 1'b0, 4'b0000, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("b_reset_gnt", 64'(gnt_b), 64'h0);
        check("b_reset_busy", 64'(busy_b), 64'h1);
        check("b_reset_rnd", 64'(rnd_b), 64'h0);
        @(negedge clk);
        rst_b = 1'b0;
        for (int i = 0; i < 19; i++) begin
            req_b = tbl[i].req;
            rs_b  = tbl[i].rs;
            @(posedge clk);
            #1;
            check($sformatf("b_gnt[%0d]", i), 64'(gnt_b), 64'(tbl[i].gnt));
            check($sformatf("b_busy[%0d]", i), 64'(busy_b), 64'(tbl[i].busy));
            check($sformatf("b_onehot[%0d]", i), 64'($countones(gnt_b) <= 1), 64'h1);
        end
        req_b = '0;
        rs_b  = 1'b0;

        // ---- A: reset with seed 0, req 0001 held ----
        #1;
        check("a_reset_gnt", 64'(gnt_a), 64'h0);
        check("a_reset_busy", 64'(busy_a), 64'h1);
        @(negedge clk);
        rst_a = 1'b0;
        model_reset();
        req_a = 4'b0001;
        for (int i = 0; i < 45; i++) begin
            step_a();
            if (gnt_a != 0) check("a_seed0_rnd", 64'(rnd_a), 64'h7);
        end

        // ---- A: randomized traffic with occasional reseeds ----
        for (int i = 0; i < 400; i++) begin
            req_a = (req_a & ~gnt_a) | (($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0);
            rs_a  = ($urandom_range(0, 39) == 0);
            seed_a = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom, $urandom};
            step_a();
        end
        rs_a = 1'b0;

        // ---- A: two reseed pulses two cycles apart ----
        req_a = '0;
        repeat (10) step_a();
        seed_a = 64'h0123_4567_89ab_cdef;
        rs_a = 1'b1;
        step_a();
        rs_a = 1'b0;
        step_a();
        seed_a = 64'h0;
        rs_a = 1'b1;
        step_a();
        rs_a = 1'b0;
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!seen) begin
                step_a();
                n++;
                if (!busy_a) seen = 1'b1;
            end
        end
        check("a_rereseed_serve_edges", 64'(n), 64'(WARMUP_A + 2));
        // Seed 0 reloaded: grants again see the all-ones pattern.
        req_a = 4'b0100;
        for (int i = 0; i < 12; i++) begin
            step_a();
            if (gnt_a != 0) check("a_reseed0_rnd", 64'(rnd_a), 64'h7);
            req_a = 4'b0100;
        end

        // ---- A: async reset in the cycle a grant would occur ----
        req_a = '0;
        repeat (5) step_a();
        req_a = 4'b0010;
        #3;
        rst_a = 1'b1;
        #1;
        check("a_midrst_gnt", 64'(gnt_a), 64'h0);
        check("a_midrst_busy", 64'(busy_a), 64'h1);
        @(posedge clk);
        #1;
        check("a_midrst_gnt_edge", 64'(gnt_a), 64'h0);
        check("a_midrst_busy_edge", 64'(busy_a), 64'h1);
        @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        model_reset();
        req_a = 4'b1001;
        for (int i = 0; i < 40; i++) begin
            step_a();
            req_a = (req_a & ~gnt_a) | 4'($urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
